// File: rtl/cpu_mem_loader.sv
// Host-side loader: streams program/data images into the cpu memories, runs the cpu
// for a programmed cycle count, then streams a data-memory window back out.
module cpu_mem_loader #(
  parameter int          CNT_W     = 16,
  parameter int          RUN_W     = 32,
  parameter logic [31:0] ADDR_STEP = 32'd4,
  parameter logic [31:0] IMEM_BASE = 32'd0,
  parameter logic [31:0] DMEM_BASE = 32'd0,
  parameter int          READ_LAT  = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] imem_words,
  input  logic [CNT_W-1:0] dmem_words,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] dump_words,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [31:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [31:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [31:0]      wdata_ext_2,
  input  logic [31:0]      rdata_ext_2,
  output logic             enable,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE, LD_I, LD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] imem_q, dmem_q, dump_q;
  logic [RUN_W-1:0] run_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RUN_W-1:0] rcnt_q, rcnt_d, rcnt_inc;
  logic [31:0]      ptr_q, ptr_d;
  logic [1:0]       wcnt_q, wcnt_d;
  logic             enter;

  logic             in_ready_d, out_valid_d, wen_d, wen2_d, ren2_d;
  logic             enable_d, busy_d, done_d;
  logic [31:0]      out_data_d, addr_d, wdata_d, addr2_d, wdata2_d;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign rcnt_inc = rcnt_q + RUN_W'(1);
  assign ren_ext  = 1'b0;

  // Zero-length phases are skipped; the flags say which phases remain.
  function automatic state_t first_phase(input logic i, input logic d,
                                         input logic r, input logic u);
    if (i)      return LD_I;
    else if (d) return LD_D;
    else if (r) return RUN;
    else if (u) return DUMP_RD;
    else        return DONE;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    ptr_d       = ptr_q;
    wcnt_d      = wcnt_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    addr_d      = addr_ext;
    wdata_d     = wdata_ext;
    addr2_d     = addr_ext_2;
    wdata2_d    = wdata_ext_2;
    wen_d       = 1'b0;
    wen2_d      = 1'b0;
    ren2_d      = 1'b0;
    enable_d    = enable;
    busy_d      = busy;
    done_d      = 1'b0;
    enter       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          enter   = 1'b1;
          state_d = first_phase(imem_words != '0, dmem_words != '0,
                                run_cycles != '0, dump_words != '0);
        end
      end
      LD_I: begin
        if (in_ready && in_valid) begin
          wen_d   = 1'b1;
          addr_d  = ptr_q;
          wdata_d = in_data;
          ptr_d   = ptr_q + ADDR_STEP;
          cnt_d   = cnt_inc;
          if (cnt_inc == imem_q) in_ready_d = 1'b0;
        end else if (!in_ready) begin
          // in_ready low here means the final write is on the bus this cycle
          enter   = 1'b1;
          state_d = first_phase(1'b0, dmem_q != '0, run_q != '0, dump_q != '0);
        end
      end
      LD_D: begin
        if (in_ready && in_valid) begin
          wen2_d   = 1'b1;
          addr2_d  = ptr_q;
          wdata2_d = in_data;
          ptr_d    = ptr_q + ADDR_STEP;
          cnt_d    = cnt_inc;
          if (cnt_inc == dmem_q) in_ready_d = 1'b0;
        end else if (!in_ready) begin
          enter   = 1'b1;
          state_d = first_phase(1'b0, 1'b0, run_q != '0, dump_q != '0);
        end
      end
      RUN: begin
        if (rcnt_inc == run_q) begin
          enable_d = 1'b0;
          enter    = 1'b1;
          state_d  = first_phase(1'b0, 1'b0, 1'b0, dump_q != '0);
        end else begin
          rcnt_d = rcnt_inc;
        end
      end
      DUMP_RD: begin
        wcnt_d  = 2'd0;
        state_d = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (wcnt_q == 2'(READ_LAT - 1)) begin
          out_data_d  = rdata_ext_2;
          out_valid_d = 1'b1;
          state_d     = DUMP_OUT;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      DUMP_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_inc;
          if (cnt_inc == dump_q) begin
            state_d = DONE;
          end else begin
            ren2_d  = 1'b1;
            addr2_d = ptr_q;
            ptr_d   = ptr_q + ADDR_STEP;
            state_d = DUMP_RD;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Phase-entry actions, so every phase's first cycle already has its outputs set.
    if (enter) begin
      cnt_d  = '0;
      rcnt_d = '0;
      case (state_d)
        LD_I: begin
          in_ready_d = 1'b1;
          ptr_d      = IMEM_BASE;
        end
        LD_D: begin
          in_ready_d = 1'b1;
          ptr_d      = DMEM_BASE;
        end
        RUN:  enable_d = 1'b1;
        DUMP_RD: begin
          ren2_d  = 1'b1;
          addr2_d = DMEM_BASE;
          ptr_d   = DMEM_BASE + ADDR_STEP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      imem_q      <= '0;
      dmem_q      <= '0;
      dump_q      <= '0;
      run_q       <= '0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      ptr_q       <= '0;
      wcnt_q      <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      ren_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      enable      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      ptr_q       <= ptr_d;
      wcnt_q      <= wcnt_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      out_data    <= out_data_d;
      addr_ext    <= addr_d;
      wen_ext     <= wen_d;
      wdata_ext   <= wdata_d;
      addr_ext_2  <= addr2_d;
      wen_ext_2   <= wen2_d;
      ren_ext_2   <= ren2_d;
      wdata_ext_2 <= wdata2_d;
      enable      <= enable_d;
      busy        <= busy_d;
      done        <= done_d;
      if (state_q == IDLE && start) begin
        imem_q <= imem_words;
        dmem_q <= dmem_words;
        run_q  <= run_cycles;
        dump_q <= dump_words;
      end
    end
  end

endmodule

// File: doc/cpu_mem_loader.md
Name: cpu_mem_loader

Overview:
- Host-side initiator for the cpu external memory ports: drives addr_ext/wen_ext/ren_ext/wdata_ext (instruction memory) and addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2 (data memory).
- Per command: streams a program into instruction memory and an initial image into data memory, then pulses the cpu enable for a programmed cycle count.
- Afterwards reads a data-memory window back out over a valid/ready stream.
- Sits between the test/host harness and the cpu top.

Parameters:
- CNT_W, 16, width of word-count inputs.
- RUN_W, 32, width of run-cycle count.
- ADDR_STEP, 4, address increment per word (byte addressing).
- IMEM_BASE, 0, first instruction-memory address.
- DMEM_BASE, 0, first data-memory address for load and dump.
- READ_LAT, 1, cycles from ren_ext_2 assertion to valid rdata_ext_2 (1..3).

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled only in IDLE
- imem_words  in  CNT_W  words to write to instruction memory
- dmem_words  in  CNT_W  words to write to data memory
- run_cycles  in  RUN_W  cycles to hold cpu enable high
- dump_words  in  CNT_W  data-memory words to read back
- in_valid  in  1  load stream valid
- in_ready  out  1  load stream ready
- in_data  in  32  load stream word
- out_valid  out  1  dump stream valid
- out_ready  in  1  dump stream ready
- out_data  out  32  dump stream word
- addr_ext  out  32  instruction-memory address
- wen_ext  out  1  instruction-memory write enable
- ren_ext  out  1  instruction-memory read enable, tied 0
- wdata_ext  out  32  instruction-memory write data
- addr_ext_2  out  32  data-memory address
- wen_ext_2  out  1  data-memory write enable
- ren_ext_2  out  1  data-memory read enable
- wdata_ext_2  out  32  data-memory write data
- rdata_ext_2  in  32  data-memory read data
- enable  out  1  cpu run enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, arst_n low): state IDLE; all outputs 0; counters 0. Reset mid-operation aborts immediately; memory contents already written are not touched.
- All outputs are registered.
- States: IDLE -> LD_I -> LD_D -> RUN -> DUMP_RD -> DUMP_WAIT -> DUMP_OUT -> DONE -> IDLE.
- IDLE:
  - start=1 latches all four counts and sets busy next cycle.
  - Each phase whose count is 0 is skipped.
  - If all counts are 0, the next state is DONE.
  - start outside IDLE is ignored.
- LD_I:
  - in_ready=1 while words remain; back-to-back accepts are allowed.
  - Each handshake k (0-based) produces, in the next cycle, wen_ext=1 for exactly one cycle, with addr_ext=IMEM_BASE+k*ADDR_STEP and wdata_ext=in_data.
  - in_ready drops the cycle after the last accept.
  - The state advances after the last write cycle.
- LD_D: identical to LD_I, but on the _2 port with DMEM_BASE.
- RUN:
  - enable=1 for exactly run_cycles consecutive cycles, then 0.
  - No external memory strobes are driven during RUN.
- DUMP_RD: ren_ext_2=1 for one cycle, with addr_ext_2=DMEM_BASE+k*ADDR_STEP.
- DUMP_WAIT:
  - READ_LAT cycles after the ren_ext_2 cycle, capture rdata_ext_2 into out_data.
  - In the same cycle, set out_valid=1.
- DUMP_OUT:
  - out_valid and out_data are held stable until out_ready=1.
  - On the handshake, out_valid=0 next cycle; go to DUMP_RD for k+1, or to DONE after the last word.
  - Only one read is outstanding at a time.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Address arithmetic is 32-bit and wraps modulo 2^32. Counters are CNT_W/RUN_W wide; the maximum count is 2^CNT_W-1 words.
- wen_ext and wen_ext_2 are never high in the same cycle.
- Strobes (wen_ext, wen_ext_2, ren_ext_2) are never high while enable=1.

Test Plan:
- Reset during LD_I after 2 of 5 words -> all outputs 0 within the reset; busy=0; start next accepted normally.
- imem_words=3, stream 0x11111111, 0x22222222, 0x33333333 back-to-back -> wen_ext pulses at addr 0x0, 0x4, 0x8 with matching data; in_ready low after 3rd accept.
- dmem_words=2 with in_valid gapped (1 idle cycle between words) -> wen_ext_2 at 0x0, 0x4 only after each handshake; no spurious writes.
- run_cycles=10 -> enable high exactly 10 cycles; no wen/ren during that window.
- dump_words=3 after loading data memory with 0xA, 0xB, 0xC, out_ready toggling 0/1 -> out_data sequence 0xA, 0xB, 0xC, each held stable while out_ready=0; done pulses once.
- All counts 0 with start=1 -> done pulses 2 cycles after start; no memory strobes or enable.
